bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter: the next generation of our decimal/BCD encoder family. It takes an arbitrary-width unsigned binary value and produces packed BCD digits using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It has a start/done handshake and out-of-range detection. It sits between binary counters/arithmetic and seven-segment or BCD display drivers.

## Interface

**Parameters**
- BIN_W, default 10: width of the binary input. Must be ≥ 1.
- DIGITS, default 4: number of BCD output digits. Must be ≥ 1.

**Ports**
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only when ready=1.
- bin  input  BIN_W  unsigned binary operand; captured on the accepting edge.
- ready  output  1  high in IDLE (new start accepted).
- busy  output  1  high while a conversion is in progress; equals ~ready.
- done  output  1  one-cycle pulse; bcd and overflow valid and updated.
- bcd  output  4*DIGITS  packed result; digit 0 (units) in bits [3:0], digit k in [4k+3:4k].
- overflow  output  1  high when bin ≥ 10^DIGITS for the last completed conversion.

## Operation

- **State machine** with two states, IDLE and SHIFT.
- **IDLE**:
  - ready=1, busy=0.
  - On a rising edge with start=1:
    - Latch bin into the shift register.
    - Clear the BCD scratch and the sticky overflow scratch.
    - Load the bit counter with BIN_W.
    - Go to SHIFT.
  - start=0 keeps IDLE.
- **SHIFT**: each edge performs one iteration.
  - (a) Every scratch digit ≥ 5 gets +3, computed combinationally on the current scratch.
  - (b) Shift {scratch, binreg} left by one. The bin MSB enters scratch bit 0.
  - (c) The bit shifted out of the top digit's MSB ORs into the overflow scratch.
  - Decrement the counter.
  - On the edge where the counter goes 1→0:
    - Load bcd from the post-iteration scratch.
    - Load overflow from the post-iteration sticky bit.
    - Assert done for the next cycle.
    - Return to IDLE.
- **Arithmetic**:
  - Adjust in 4-bit digits, with no carry between digits.
  - Output digits are always 0–9.
  - On overflow, bcd = bin mod 10^DIGITS.
- **Start handling**: start while busy is ignored, not queued. bin changes while busy have no effect.
- **Output holding**: bcd and overflow hold their last values between done pulses. They change only on a done edge or on reset.
- **Reset**: rst asserted at any time (including mid-SHIFT) immediately forces:
  - state IDLE;
  - ready=1, busy=0, done=0, bcd=0, overflow=0;
  - counter and scratch cleared.
  - An interrupted conversion produces no done.
- **Counter width**: $clog2(BIN_W+1) bits.

## Timing

- **Accepting edge**: edge E0, with ready=1 and start=1. busy=1 and ready=0 from just after E0.
- **Latency**: the final iteration occurs at edge E0+BIN_W.
  - done=1, new bcd/overflow, ready=1 and busy=0 all appear during the cycle after E0+BIN_W.
  - done is exactly one cycle wide.
- **Back-to-back**: start held high during the done cycle is accepted at edge E0+BIN_W+1. Minimum conversion period is BIN_W+1 cycles.
- **BIN_W=1**: a single SHIFT cycle; done follows E0+1.
- **Reset**: deassertion is followed by IDLE. The first start is accepted at the first rising edge with rst=0.

## Test plan

- **Default, 1023**: BIN_W=10, DIGITS=4, bin=1023, start pulse at E0 → done exactly after E0+10; bcd=16'h1023, overflow=0; busy high for 10 cycles.
- **Zero input**: bin=0 → bcd=16'h0000, overflow=0. bin=10'b0010101010 (170) → bcd=16'h0170.
- **Overflow boundary**: DIGITS=3, BIN_W=10.
  - bin=999 → bcd=12'h999, overflow=0.
  - bin=1000 → bcd=12'h000, overflow=1.
  - bin=1023 → bcd=12'h023, overflow=1.
- **Start while busy**: start asserted mid-SHIFT with a different bin → ignored. The first result is unchanged and only one done pulse is seen.
- **Back-to-back**: start held high continuously with bin alternating 5, 9 → done pulses every 11 cycles; bcd=0x0005, then 0x0009.
- **Reset mid-conversion**: rst asserted 4 cycles after E0 → outputs zero immediately, no done. A fresh conversion of 42 after release → bcd=16'h0042.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double-dabble, one
// input bit per clock) with start/done handshake and out-of-range flag.
//
// Parameters
//   BIN_W   width of the unsigned binary operand (>= 1)
//   DIGITS  number of packed BCD output digits (>= 1)
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     conversion request, sampled only while ready
//   bin       binary operand, captured on the accepting edge
//   ready     idle, a start will be accepted
//   busy      conversion in progress (~ready)
//   done      one-cycle pulse, bcd/overflow just updated
//   bcd       packed result, digit k in [4k+3:4k]
//   overflow  last completed operand was >= 10^DIGITS
module bin_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [SW-1:0]   scr_q, scr_d;
  logic            ovf_sc_q, ovf_sc_d;
  logic [SW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  // One double-dabble iteration on the current scratch.
  logic [SW-1:0]   adj;
  logic [SW-1:0]   scr_sh;
  logic            top_out;

  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      // Digits are independent: max 9+3 = 12 still fits in 4 bits.
      adj[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? scr_q[4*k +: 4] + 4'd3
                                                 : scr_q[4*k +: 4];
    end
    top_out = adj[SW-1];
    scr_sh  = {adj[SW-2:0], bin_q[BIN_W-1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    scr_d    = scr_q;
    ovf_sc_d = ovf_sc_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d    = bin;
          scr_d    = '0;
          ovf_sc_d = 1'b0;
          cnt_d    = CW'(BIN_W);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        scr_d    = scr_sh;
        bin_d    = bin_q << 1;
        // A bit leaving the top digit means the value reached 10^DIGITS;
        // the lower digits keep tracking the value modulo 10^DIGITS.
        ovf_sc_d = ovf_sc_q | top_out;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_sh;
          ovf_d   = ovf_sc_q | top_out;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_q    <= '0;
      scr_q    <= '0;
      ovf_sc_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      scr_q    <= scr_d;
      ovf_sc_q <= ovf_sc_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign busy     = ~ready;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench: 4-digit and 3-digit converters (BIN_W=10) plus a
// 1-bit/1-digit instance, sharing clock, reset, start and operand.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  bin;

  logic        ready4, busy4, done4, ovf4;
  logic [15:0] bcd4;
  logic        ready3, busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        ready1, busy1, done1, ovf1;
  logic [3:0]  bcd1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready4), .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4));

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready3), .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3));

  bin_to_bcd_seq #(.BIN_W(1), .DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bin(bin[0:0]),
    .ready(ready1), .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns cycles until done4 (bounded) and the
  // cycle on which done1 first pulsed (-1 if never).
  task automatic wait_done(output int lat, output int lat1);
    lat  = 0;
    lat1 = -1;
    while (!done4 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done1 && lat1 < 0) lat1 = lat;
    end
  endtask

  task automatic conv(input logic [9:0] v, input logic [15:0] e4, input logic eo4,
                      input logic [11:0] e3, input logic eo3);
    int lat, lat1;
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy4, 1);
    chk("ready_after_accept", ready4, 0);
    wait_done(lat, lat1);
    chk("latency", lat, 10);
    chk("bcd4", bcd4, e4);
    chk("ovf4", ovf4, eo4);
    chk("bcd3", bcd3, e3);
    chk("ovf3", ovf3, eo3);
    chk("ready_at_done", ready4, 1);
    chk("w1_latency", lat1, 1);
    chk("w1_bcd", bcd1, {3'b000, v[0]});
    @(posedge clk); #1;
    chk("done_width", done4, 0);
    chk("bcd4_hold", bcd4, e4);
  endtask

  initial begin
    int lat, lat1, ndone;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready4, 1);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_bcd", bcd4, 0);
    chk("rst_ovf", ovf4, 0);
    rst = 1'b0;

    conv(10'd1023, 16'h1023, 1'b0, 12'h023, 1'b1);
    conv(10'd0,    16'h0000, 1'b0, 12'h000, 1'b0);
    conv(10'd170,  16'h0170, 1'b0, 12'h170, 1'b0);
    conv(10'd999,  16'h0999, 1'b0, 12'h999, 1'b0);
    conv(10'd1000, 16'h1000, 1'b0, 12'h000, 1'b1);

    // Start while busy: second request must be dropped.
    start = 1'b1; bin = 10'd321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; bin = 10'd77;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, lat1);
    chk("busy_start_latency", lat, 6);
    chk("busy_start_bcd", bcd4, 16'h0321);
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    chk("busy_start_single_done", ndone, 0);
    chk("busy_start_hold", bcd4, 16'h0321);

    // Back-to-back with start held high.
    start = 1'b1; bin = 10'd5;
    @(posedge clk); #1;
    bin = 10'd9;
    wait_done(lat, lat1);
    chk("b2b_lat0", lat, 10);
    chk("b2b_bcd0", bcd4, 16'h0005);
    @(posedge clk); #1;
    chk("b2b_reaccept", busy4, 1);
    chk("b2b_done_drop", done4, 0);
    bin = 10'd5;
    wait_done(lat, lat1);
    start = 1'b0;
    chk("b2b_lat1", lat, 10);
    chk("b2b_bcd1", bcd4, 16'h0009);
    @(posedge clk); #1;
    chk("b2b_idle", ready4, 1);

    // Reset mid-conversion.
    start = 1'b1; bin = 10'd500;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_bcd", bcd4, 0);
    chk("mid_rst_ovf3", ovf3, 0);
    chk("mid_rst_ready", ready4, 1);
    chk("mid_rst_busy", busy4, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);
    conv(10'd42, 16'h0042, 1'b0, 12'h042, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
